// File: rtl/spdif_pkg.sv
// Shared S/PDIF framing definitions: subframe geometry, block length and
// the sequencer state type used by frame_sequencer and frame_dismantle.
package spdif_pkg;

  localparam int SUBFRAME_BITS_C    = 28;
  localparam int FRAMES_PER_BLOCK_C = 192;

  // Bit offsets inside a 28-bit subframe, LSB first on the wire
  localparam int AUX_LSB_C  = 0;
  localparam int AUX_W_C    = 4;
  localparam int DATA_LSB_C = 4;
  localparam int DATA_W_C   = 20;
  localparam int V_BIT_C    = 24;
  localparam int U_BIT_C    = 25;
  localparam int C_BIT_C    = 26;
  localparam int P_BIT_C    = 27;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/frame_sequencer_idle_watchdog.sv
// Stall watchdog: counts consecutive idle cycles and pulses expired on the
// TIMEOUT-th one; clear has priority and restarts the count from zero.
module idle_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_reg;

  assign expired = count_en && !clear && (timer_reg == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (rst || clear || expired) begin
      timer_reg <= '0;
    end else if (count_en) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Locks to block-start sync, forwards the serial stream with a one-cycle
// latency and tags each bit with its frame index and channel.
module frame_sequencer
  import spdif_pkg::*;
#(
  parameter int SUBFRAME_BITS    = SUBFRAME_BITS_C,
  parameter int FRAMES_PER_BLOCK = FRAMES_PER_BLOCK_C,
  parameter int TIMEOUT          = 4096,
  parameter int BLK_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             bit_valid_in,
  input  logic             bit_in,
  input  logic             sync_in,
  input  logic             kill_in,
  input  logic             done_in,
  output logic             bit_valid_out,
  output logic             bit_out,
  output logic [7:0]       frame_counter,
  output logic             in_channel,
  output logic             locked,
  output logic             block_start,
  output logic [BLK_W-1:0] block_count,
  output logic [7:0]       err_count
);

  localparam int CW = $clog2(SUBFRAME_BITS);
  localparam logic [CW-1:0] LAST_BIT   = CW'(SUBFRAME_BITS - 1);
  localparam logic [7:0]    LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);

  seq_state_t       state_reg, state_next;
  logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]       fc_reg, fc_next;
  logic             ch_reg, ch_next;
  logic             bit_out_reg, bit_out_next;
  logic             bit_valid_out_reg, bit_valid_out_next;
  logic [7:0]       frame_counter_reg, frame_counter_next;
  logic             in_channel_reg, in_channel_next;
  logic             block_start_reg, block_start_next;
  logic             locked_reg, locked_next;
  logic [BLK_W-1:0] block_count_reg, block_count_next;
  logic [7:0]       err_count_reg, err_count_next;

  logic aligned;
  logic start_block;
  logic err_inc;
  logic wd_count_en;
  logic wd_expired;

  // Only idle cycles inside LOCKED advance the watchdog; anything else restarts it
  assign wd_count_en = enable && (state_reg == LOCKED) && !bit_valid_in;

  idle_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (!wd_count_en),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );

  assign aligned = (bit_cnt_reg == '0) && (fc_reg == '0) && !ch_reg;

  always_comb begin
    state_next         = state_reg;
    bit_cnt_next       = bit_cnt_reg;
    fc_next            = fc_reg;
    ch_next            = ch_reg;
    bit_out_next       = bit_out_reg;
    bit_valid_out_next = 1'b0;
    frame_counter_next = frame_counter_reg;
    in_channel_next    = in_channel_reg;
    block_start_next   = 1'b0;
    block_count_next   = block_count_reg;
    err_count_next     = err_count_reg;
    start_block        = 1'b0;
    err_inc            = 1'b0;

    if (!enable) begin
      state_next         = IDLE;
      bit_cnt_next       = '0;
      fc_next            = '0;
      ch_next            = 1'b0;
      bit_out_next       = 1'b0;
      frame_counter_next = '0;
      in_channel_next    = 1'b0;
      block_count_next   = '0;
      err_count_next     = '0;
    end else begin
      unique case (state_reg)
        IDLE: state_next = HUNT;
        HUNT: begin
          if (bit_valid_in && sync_in) begin
            start_block = 1'b1;
            state_next  = LOCKED;
          end
        end
        LOCKED: begin
          if (bit_valid_in) begin
            // A kill alongside sync still marks the bit as a block start
            if (sync_in && (!aligned || kill_in)) begin
              start_block = 1'b1;
              err_inc     = !kill_in;
            end else begin
              bit_out_next       = bit_in;
              bit_valid_out_next = 1'b1;
              frame_counter_next = fc_reg;
              in_channel_next    = ch_reg;
              block_start_next   = aligned;
              if (bit_cnt_reg == LAST_BIT) begin
                bit_cnt_next = '0;
                ch_next      = !ch_reg;
                if (ch_reg) begin
                  fc_next = (fc_reg == LAST_FRAME) ? 8'd0 : fc_reg + 8'd1;
                end
              end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
              end
            end
          end
          if (kill_in || wd_expired) begin
            state_next = HUNT;
            err_inc    = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase

      if (start_block) begin
        bit_out_next       = bit_in;
        bit_valid_out_next = 1'b1;
        frame_counter_next = '0;
        in_channel_next    = 1'b0;
        block_start_next   = 1'b1;
        bit_cnt_next       = CW'(1);
        fc_next            = '0;
        ch_next            = 1'b0;
      end

      if (done_in && !kill_in) begin
        block_count_next = block_count_reg + 1'b1;
      end

      if (err_inc && (err_count_reg != 8'hFF)) begin
        err_count_next = err_count_reg + 8'd1;
      end
    end

    locked_next = (state_next == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      bit_cnt_reg       <= '0;
      fc_reg            <= '0;
      ch_reg            <= 1'b0;
      bit_out_reg       <= 1'b0;
      bit_valid_out_reg <= 1'b0;
      frame_counter_reg <= '0;
      in_channel_reg    <= 1'b0;
      block_start_reg   <= 1'b0;
      locked_reg        <= 1'b0;
      block_count_reg   <= '0;
      err_count_reg     <= '0;
    end else begin
      state_reg         <= state_next;
      bit_cnt_reg       <= bit_cnt_next;
      fc_reg            <= fc_next;
      ch_reg            <= ch_next;
      bit_out_reg       <= bit_out_next;
      bit_valid_out_reg <= bit_valid_out_next;
      frame_counter_reg <= frame_counter_next;
      in_channel_reg    <= in_channel_next;
      block_start_reg   <= block_start_next;
      locked_reg        <= locked_next;
      block_count_reg   <= block_count_next;
      err_count_reg     <= err_count_next;
    end
  end

  assign bit_valid_out = bit_valid_out_reg;
  assign bit_out       = bit_out_reg;
  assign frame_counter = frame_counter_reg;
  assign in_channel    = in_channel_reg;
  assign block_start   = block_start_reg;
  assign locked        = locked_reg;
  assign block_count   = block_count_reg;
  assign err_count     = err_count_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: a position-in-block reference model
// queues expected forwarded bits, a negedge monitor pops and compares them.
module tb_frame_sequencer;

  localparam int TIMEOUT    = 4096;
  localparam int BLK_W      = 16;
  localparam int BLOCK_BITS = 192 * 2 * 28;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             bit_valid_in;
  logic             bit_in;
  logic             sync_in;
  logic             kill_in;
  logic             done_in;
  logic             bit_valid_out;
  logic             bit_out;
  logic [7:0]       frame_counter;
  logic             in_channel;
  logic             locked;
  logic             block_start;
  logic [BLK_W-1:0] block_count;
  logic [7:0]       err_count;

  frame_sequencer #(
    .TIMEOUT (TIMEOUT),
    .BLK_W   (BLK_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bit_valid_in  (bit_valid_in),
    .bit_in        (bit_in),
    .sync_in       (sync_in),
    .kill_in       (kill_in),
    .done_in       (done_in),
    .bit_valid_out (bit_valid_out),
    .bit_out       (bit_out),
    .frame_counter (frame_counter),
    .in_channel    (in_channel),
    .locked        (locked),
    .block_start   (block_start),
    .block_count   (block_count),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit b;
    int fc;
    bit ch;
    bit bs;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;

  // Reference model: lock state, position inside the block, statistics
  int m_state = 0;  // 0 idle, 1 hunting, 2 locked
  int m_pos   = 0;
  int m_idle  = 0;
  int m_err   = 0;
  int m_blk   = 0;
  bit m_cleared = 1'b1;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  task automatic push_bit(input bit b, input int pos, input bit bs);
    exp_t e;
    e.b   = b;
    e.fc  = pos / 56;
    e.ch  = ((pos / 28) % 2) == 1;
    e.bs  = bs;
    e.due = edge_cnt + 1;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit v, input bit b, input bit s, input bit k, input bit d);
    bit inc;
    bit lost;
    inc = 1'b0;
    if (rst || !enable) begin
      m_state = 0; m_pos = 0; m_idle = 0; m_err = 0; m_blk = 0;
      m_cleared = 1'b1;
      return;
    end
    m_cleared = 1'b0;
    if (d && !k) m_blk = (m_blk + 1) % 65536;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (v && s) begin
          push_bit(b, 0, 1'b1);
          m_pos = 1; m_idle = 0; m_state = 2;
        end
      end
      default: begin
        if (v) begin
          m_idle = 0;
          if (s && (m_pos != 0 || k)) begin
            push_bit(b, 0, 1'b1);
            m_pos = 1;
            inc = !k;
          end else begin
            push_bit(b, m_pos, m_pos == 0);
            m_pos = (m_pos + 1) % BLOCK_BITS;
          end
        end else begin
          m_idle++;
        end
        lost = k || (m_idle == TIMEOUT);
        if (lost) begin
          m_state = 1; m_idle = 0; inc = 1'b1;
        end
      end
    endcase
    if (inc && m_err < 255) m_err++;
  endtask

  task automatic check_status();
    chk("locked", int'(locked), (m_state == 2) ? 1 : 0);
    chk("err_count", int'(err_count), m_err);
    chk("block_count", int'(block_count), m_blk);
    if (m_cleared) begin
      chk("cleared_valid", int'(bit_valid_out), 0);
      chk("cleared_bit", int'(bit_out), 0);
      chk("cleared_frame_counter", int'(frame_counter), 0);
      chk("cleared_in_channel", int'(in_channel), 0);
      chk("cleared_block_start", int'(block_start), 0);
    end
  endtask

  task automatic drive(input bit v, input bit b, input bit s, input bit k, input bit d);
    bit_valid_in = v; bit_in = b; sync_in = s; kill_in = k; done_in = d;
    model_step(v, b, s, k, d);
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic rbit();
    drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sync_bit();
    drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic stream_to(input int target);
    for (int i = 0; i < BLOCK_BITS && m_pos != target; i++) rbit();
  endtask

  // Monitor: every forwarded bit must match the oldest expectation, on time
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bit_valid_out === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fwd_unexpected: got bit=%0b fc=%0d ch=%0b bs=%0b expected no output (edge %0d)",
                 bit_out, frame_counter, in_channel, block_start, edge_cnt);
      end else begin
        e = exp_q.pop_front();
        if (bit_out !== e.b || frame_counter !== 8'(e.fc) || in_channel !== e.ch ||
            block_start !== e.bs || edge_cnt != e.due) begin
          n_fail++;
          $display("FAIL fwd_bit: got bit=%0b fc=%0d ch=%0b bs=%0b edge=%0d expected bit=%0b fc=%0d ch=%0b bs=%0b edge=%0d",
                   bit_out, frame_counter, in_channel, block_start, edge_cnt,
                   e.b, e.fc, e.ch, e.bs, e.due);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b1;
    bit_valid_in = 1'b0; bit_in = 1'b0; sync_in = 1'b0; kill_in = 1'b0; done_in = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    $display("reset: outputs checked zero");

    for (int i = 0; i < 50; i++) rbit();
    $display("no-sync stream: 50 bits, err=%0d", err_count);

    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < BLOCK_BITS; i++) begin
        drive(1'b1, 1'($urandom_range(0, 1)), i == 0, 1'b0, i == BLOCK_BITS - 1);
      end
    end
    $display("two aligned blocks: block_count=%0d err=%0d", block_count, err_count);

    stream_to(5 * 56 + 28 + 10);
    sync_bit();
    for (int i = 0; i < 100; i++) rbit();
    $display("misaligned sync: err=%0d", err_count);

    stream_to(191 * 56 + 5);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) rbit();
    sync_bit();
    for (int i = 0; i < 30; i++) rbit();
    $display("kill at frame 191: locked=%0d err=%0d", locked, err_count);

    for (int i = 0; i < TIMEOUT - 1; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) rbit();
    for (int i = 0; i < TIMEOUT; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) rbit();
    $display("watchdog: locked=%0d err=%0d", locked, err_count);

    sync_bit();
    for (int i = 0; i < 40; i++) rbit();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) rbit();
    $display("sync with kill: locked=%0d err=%0d", locked, err_count);

    for (int i = 0; i < 300; i++) sync_bit();
    $display("error saturation: err=%0d", err_count);

    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0,
            $urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0);
    end
    enable = 1'b1;
    $display("random traffic: block_count=%0d err=%0d", block_count, err_count);

    sync_bit();
    stream_to(100 * 56 + 13);
    rst = 1'b1;
    rbit();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) rbit();
    sync_bit();
    stream_to(100 * 56 + 13);
    enable = 1'b0;
    rbit();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) rbit();
    sync_bit();
    for (int i = 0; i < 10; i++) rbit();
    $display("mid-subframe reset and disable: locked=%0d", locked);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pending_outputs", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
